ej32_mem_arb: RTL and testbench
===============================

EJ32_MEM_ARB -- requirements
Module: ej32_mem_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of requesting channels (1..8).
REQ-002 SHALL have parameter AW, default 17, meaning byte address width (128 KB SRAM).
REQ-003 SHALL have parameter DW, default 32, meaning channel data width in bits (8, 16 or 32).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port req, input, NCH, meaning per-channel request level.
REQ-007 SHALL have port we, input, NCH, meaning per-channel write (1) or read (0).
REQ-008 SHALL have port sz, input, 2*NCH, meaning per-channel size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port addr, input, AW*NCH, meaning per-channel start byte address.
REQ-010 SHALL have port wdata, input, DW*NCH, meaning per-channel write data, right-justified.
REQ-011 SHALL have port ack, output, NCH, meaning one-cycle completion pulse per channel.
REQ-012 SHALL have port err, output, 1, meaning valid with ack: 1 = request rejected.
REQ-013 SHALL have port rdata, output, DW, meaning read result, valid in the ack cycle.
REQ-014 SHALL have port mem_a, output, AW, meaning SRAM byte address.
REQ-015 SHALL have port mem_we, output, 1, meaning SRAM byte write enable.
REQ-016 SHALL have port mem_wd, output, 8, meaning SRAM write byte.
REQ-017 SHALL have port mem_rd, input, 8, meaning SRAM read byte, valid in the same clk cycle as mem_a (SRAM clocked on falling edge).
REQ-018 SHALL have ports busy (1) and gnt (clog2(NCH), min 1), output, meaning transfer in progress and granted channel index, for tracing.

Function
REQ-019 SHALL implement FSM states IDLE, XFER, DONE.
REQ-020 In IDLE with any req high, SHALL grant round-robin starting at channel ptr, latch that channel's we, sz, addr, wdata, set byte counter n = 2^sz - 1, and enter XFER next cycle.
REQ-021 In IDLE with no req, SHALL stay in IDLE with mem_we=0.
REQ-022 In XFER, SHALL move exactly one byte per cycle, big-endian: the first cycle addresses base (MSB), each later cycle base+1..base+n.
REQ-023 Address increments SHALL wrap modulo 2^AW; no alignment is required.
REQ-024 On write, mem_we=1 and mem_wd = the corresponding byte of latched wdata in each XFER cycle.
REQ-025 On read, each mem_rd byte SHALL shift into an accumulator; rdata is the result zero-extended to DW.
REQ-026 After the cycle with counter 0, SHALL enter DONE: ack[gnt]=1 for exactly one cycle, then return to IDLE.
REQ-027 On leaving DONE, ptr SHALL advance to gnt+1 mod NCH.
REQ-028 Latency from grant cycle to ack SHALL be 2^sz + 1 cycles: byte 2, half 3, word 5.
REQ-029 If sz=3 or 8*2^sz > DW, SHALL skip XFER, go IDLE->DONE, and pulse ack with err=1, rdata=0 and no memory write.
REQ-030 A requester SHALL hold req and its inputs stable until ack; inputs changing after grant SHALL NOT affect the transfer (latched).
REQ-031 If req drops mid-transfer, the transfer SHALL complete and ack SHALL still pulse.
REQ-032 If req is still high in the cycle after ack, SHALL treat it as a new request subject to arbitration.
REQ-033 Simultaneous requests SHALL be served one transfer at a time; no channel waits more than NCH-1 transfers.
REQ-034 rdata and err SHALL hold their last value outside ack cycles.
REQ-035 mem_we SHALL be 0 in every cycle not in XFER-write and in every cycle rst is low.

Reset
REQ-036 With rst low at a rising edge, SHALL set state=IDLE, ptr=0, gnt=0, busy=0, ack=0, err=0, rdata=0, mem_a=0, mem_wd=0.
REQ-037 Reset mid-transfer SHALL abort without ack; bytes already written remain in SRAM.

Verification
REQ-038 Word write ch0 addr 0x1000 wdata 0x11223344 -> SRAM[0x1000..0x1003] = 11,22,33,44; ack[0] 5 cycles after grant.
REQ-039 Half read ch1 addr 0x1FFFF over SRAM[0x1FFFF]=AB, SRAM[0x00000]=CD -> addresses wrap; rdata=0x0000ABCD; ack[1] at grant+3.
REQ-040 ch0 and ch1 requesting continuously with byte reads -> grants alternate 0,1,0,1; each ack one cycle wide.
REQ-041 DW=16, sz=2 request -> ack with err=1 at grant+1, mem_we never 1.
REQ-042 rst low during the 3rd byte of a word write -> no ack, mem_we=0, state IDLE next cycle, bytes 1-2 written.
REQ-043 Back-to-back ch0 byte writes with req held high -> a second grant in the cycle after ack; ptr advance does not starve ch0 when alone.

Source files
------------

// File: rtl/ej32_mem_arb.sv
// Round-robin arbiter that serialises byte/half/word channel requests onto a
// byte-wide SRAM port, one byte per cycle, big-endian.
module ej32_mem_arb #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 17,
  parameter int unsigned DW  = 32,
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [2*NCH-1:0]  sz,
  input  logic [AW*NCH-1:0] addr,
  input  logic [DW*NCH-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_a,
  output logic              mem_we,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd,
  output logic              busy,
  output logic [GW-1:0]     gnt
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t         r_state;
  logic [GW-1:0]  r_ptr;
  logic [GW-1:0]  r_gnt;
  logic           r_we;
  logic [1:0]     r_cnt;
  logic [DW-1:0]  r_wdata;
  logic [23:0]    r_acc;
  logic [NCH-1:0] r_ack;
  logic           r_err;
  logic [DW-1:0]  r_rdata;
  logic [AW-1:0]  r_mem_a;
  logic           r_mem_we;
  logic [7:0]     r_mem_wd;
  logic           r_busy;

  logic           w_found;
  logic [GW-1:0]  w_pick;
  int unsigned    w_k;
  int unsigned    w_pi;
  logic [1:0]     w_sz;
  logic [1:0]     w_n;
  logic           w_bad;
  logic [31:0]    w_cwd;
  logic [31:0]    w_lwd;

  // First requesting channel at or after r_ptr, wrapping modulo NCH.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_k = (32'(r_ptr) + i) % NCH;
      if (!w_found && req[w_k]) begin
        w_found = 1'b1;
        w_pick  = GW'(w_k);
      end
    end
  end

  always_comb begin
    w_pi  = 32'(w_pick);
    w_sz  = sz[2*w_pi +: 2];
    w_cwd = 32'(wdata[DW*w_pi +: DW]);
    w_lwd = 32'(r_wdata);
    case (w_sz)
      2'd1:    w_n = 2'd1;
      2'd2:    w_n = 2'd3;
      default: w_n = 2'd0;
    endcase
    w_bad = (w_sz == 2'd3) || ((32'd8 << w_sz) > DW);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_wdata  <= '0;
      r_acc    <= '0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_mem_a  <= '0;
      r_mem_we <= 1'b0;
      r_mem_wd <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_pick;
            r_we    <= we[w_pi];
            r_cnt   <= w_n;
            r_wdata <= wdata[DW*w_pi +: DW];
            r_acc   <= '0;
            r_busy  <= 1'b1;
            if (w_bad) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_ack   <= NCH'(1) << w_pick;
            end else begin
              r_state  <= S_XFER;
              r_mem_a  <= addr[AW*w_pi +: AW];
              r_mem_we <= we[w_pi];
              r_mem_wd <= w_cwd[8*32'(w_n) +: 8];
            end
          end
        end
        S_XFER: begin
          r_acc <= {r_acc[15:0], mem_rd};
          if (r_cnt == 2'd0) begin
            r_state  <= S_DONE;
            r_mem_we <= 1'b0;
            r_err    <= 1'b0;
            r_ack    <= NCH'(1) << r_gnt;
            if (!r_we) r_rdata <= DW'({r_acc, mem_rd});
          end else begin
            r_cnt    <= r_cnt - 2'd1;
            r_mem_a  <= r_mem_a + AW'(1);
            r_mem_wd <= w_lwd[8*32'(r_cnt - 2'd1) +: 8];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= (r_gnt == GW'(NCH-1)) ? '0 : r_gnt + GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack    = r_ack;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign mem_a  = r_mem_a;
  // Gated by rst so a reset landing mid-write suppresses that cycle's byte.
  assign mem_we = r_mem_we & rst;
  assign mem_wd = r_mem_wd;
  assign busy   = r_busy;
  assign gnt    = r_gnt;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: vector table of single transfers plus
// sequences for arbitration, back-to-back grants, reset abort and DW=16 rejects.
module tb_ej32_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, we;
  logic [3:0]  sz;
  logic [33:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic [16:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;
  logic        busy;
  logic [0:0]  gnt;

  logic [1:0]  u_req, u_we;
  logic [3:0]  u_sz;
  logic [33:0] u_addr;
  logic [31:0] u_wdata;
  logic [1:0]  u_ack;
  logic        u_err;
  logic [15:0] u_rdata;
  logic [16:0] u_mem_a;
  logic        u_mem_we;
  logic [7:0]  u_mem_wd;
  logic [7:0]  u_mem_rd;
  logic        u_busy;
  logic [0:0]  u_gnt;
  assign u_mem_rd = '0;

  ej32_mem_arb #(.NCH(2), .AW(17), .DW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .gnt(gnt)
  );

  ej32_mem_arb #(.NCH(2), .AW(17), .DW(16)) u16 (
    .clk(clk), .rst(rst), .req(u_req), .we(u_we), .sz(u_sz), .addr(u_addr), .wdata(u_wdata),
    .ack(u_ack), .err(u_err), .rdata(u_rdata), .mem_a(u_mem_a), .mem_we(u_mem_we),
    .mem_wd(u_mem_wd), .mem_rd(u_mem_rd), .busy(u_busy), .gnt(u_gnt)
  );

  // Falling-edge SRAM model
  logic [7:0] mem [0:(1<<17)-1];
  int n_writes = 0;
  bit u_we_seen = 1'b0;
  always @(negedge clk) begin
    mem_rd <= mem[mem_a];
    if (mem_we) begin
      mem[mem_a] <= mem_wd;
      n_writes   <= n_writes + 1;
    end
    if (u_mem_we) u_we_seen <= 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (ack == 2'b00 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic set_ch(input int ch, input bit w, input logic [1:0] s,
                        input logic [16:0] a, input logic [31:0] d);
    we[ch] = w;
    sz[2*ch +: 2] = s;
    addr[17*ch +: 17] = a;
    wdata[32*ch +: 32] = d;
  endtask

  typedef struct {
    int          ch;
    bit          w;
    logic [1:0]  s;
    logic [16:0] a;
    logic [31:0] d;
    int          lat;
    bit          e;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] last_rd;
    int lat;

    tv[0]  = '{0, 1'b1, 2'd2, 17'h01000, 32'h11223344, 5, 1'b0, 32'h0};
    tv[1]  = '{0, 1'b1, 2'd1, 17'h1FFFF, 32'h0000ABCD, 3, 1'b0, 32'h0};
    tv[2]  = '{1, 1'b0, 2'd1, 17'h1FFFF, 32'h0,        3, 1'b0, 32'h0000ABCD};
    tv[3]  = '{1, 1'b0, 2'd2, 17'h01000, 32'h0,        5, 1'b0, 32'h11223344};
    tv[4]  = '{0, 1'b1, 2'd0, 17'h02000, 32'hFFFFFFA5, 2, 1'b0, 32'h0};
    tv[5]  = '{0, 1'b0, 2'd0, 17'h02000, 32'h0,        2, 1'b0, 32'h000000A5};
    tv[6]  = '{1, 1'b1, 2'd2, 17'h03001, 32'hDEADBEEF, 5, 1'b0, 32'h0};
    tv[7]  = '{0, 1'b0, 2'd3, 17'h03001, 32'h0,        1, 1'b1, 32'h0};
    tv[8]  = '{1, 1'b0, 2'd1, 17'h03003, 32'h0,        3, 1'b0, 32'h0000BEEF};
    tv[9]  = '{1, 1'b1, 2'd3, 17'h00010, 32'h12345678, 1, 1'b1, 32'h0};
    tv[10] = '{0, 1'b0, 2'd2, 17'h03001, 32'h0,        5, 1'b0, 32'hDEADBEEF};
    tv[11] = '{0, 1'b1, 2'd2, 17'h04000, 32'h00000000, 5, 1'b0, 32'h0};

    rst = 1'b0; req = '0; we = '0; sz = '0; addr = '0; wdata = '0;
    u_req = '0; u_we = '0; u_sz = '0; u_addr = '0; u_wdata = '0;
    tick(); tick();
    check("rst_ack",    32'(ack),    32'h0);
    check("rst_err",    32'(err),    32'h0);
    check("rst_rdata",  rdata,       32'h0);
    check("rst_mem_a",  32'(mem_a),  32'h0);
    check("rst_mem_wd", 32'(mem_wd), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_gnt",    32'(gnt),    32'h0);
    rst = 1'b1;
    tick();
    check("idle_mem_we", 32'(mem_we), 32'h0);
    last_rd = 32'h0;

    for (int i = 0; i < 12; i++) begin
      int nb;
      int w0;
      logic [31:0] exp_rd;
      logic [1:0]  exp_ack;
      nb = 1 << tv[i].s;
      w0 = n_writes;
      exp_ack = 2'b01 << tv[i].ch;
      set_ch(tv[i].ch, tv[i].w, tv[i].s, tv[i].a, tv[i].d);
      req = exp_ack;
      tick();
      check($sformatf("v%0d_gnt", i),  32'(gnt),  32'(tv[i].ch));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      wait_ack(lat);
      lat += 1;
      req = '0;
      exp_rd = (tv[i].w && !tv[i].e) ? last_rd : tv[i].rd;
      last_rd = exp_rd;
      check($sformatf("v%0d_lat", i),   32'(lat), 32'(tv[i].lat));
      check($sformatf("v%0d_ack", i),   32'(ack), 32'(exp_ack));
      check($sformatf("v%0d_err", i),   32'(err), 32'(tv[i].e));
      check($sformatf("v%0d_rdata", i), rdata,    exp_rd);
      tick();
      check($sformatf("v%0d_ack_off", i),  32'(ack), 32'h0);
      check($sformatf("v%0d_err_hold", i), 32'(err), 32'(tv[i].e));
      check($sformatf("v%0d_rd_hold", i),  rdata,    exp_rd);
      check($sformatf("v%0d_nwrites", i), 32'(n_writes),
            32'(w0 + ((tv[i].w && !tv[i].e) ? nb : 0)));
      if (tv[i].w && !tv[i].e) begin
        for (int b = 0; b < nb; b++) begin
          logic [16:0] ma;
          logic [31:0] dv;
          ma = tv[i].a + 17'(b);
          dv = tv[i].d;
          check($sformatf("v%0d_mem%0d", i, b), 32'(mem[ma]), 32'(dv[8*(nb-1-b) +: 8]));
        end
      end
    end

    // Reset during the third byte of a word write
    set_ch(0, 1'b1, 2'd2, 17'h04000, 32'hCAFEF00D);
    req = 2'b01;
    tick(); tick(); tick();
    check("rsta_we_before", 32'(mem_we), 32'h1);
    rst = 1'b0;
    #1;
    check("rsta_we_gated", 32'(mem_we), 32'h0);
    tick();
    check("rsta_ack",   32'(ack),   32'h0);
    check("rsta_busy",  32'(busy),  32'h0);
    check("rsta_we",    32'(mem_we), 32'h0);
    check("rsta_mem_a", 32'(mem_a), 32'h0);
    check("rsta_rdata", rdata,      32'h0);
    check("rsta_gnt",   32'(gnt),   32'h0);
    rst = 1'b1;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rsta_noack%0d", k), 32'(ack), 32'h0);
    end
    check("rsta_m0", 32'(mem[17'h04000]), 32'hCA);
    check("rsta_m1", 32'(mem[17'h04001]), 32'hFE);
    check("rsta_m2", 32'(mem[17'h04002]), 32'h00);
    check("rsta_m3", 32'(mem[17'h04003]), 32'h00);

    // Two channels requesting continuously: grants alternate from ptr=0
    set_ch(0, 1'b0, 2'd0, 17'h02000, 32'h0);
    set_ch(1, 1'b0, 2'd0, 17'h01000, 32'h0);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic [1:0]  ea;
      logic [31:0] er;
      ea = (t % 2 == 0) ? 2'b01 : 2'b10;
      er = (t % 2 == 0) ? 32'h000000A5 : 32'h00000011;
      wait_ack(lat);
      if (t == 3) req = '0;
      check($sformatf("alt%0d_lat", t),   32'(lat), 32'd2);
      check($sformatf("alt%0d_ack", t),   32'(ack), 32'(ea));
      check($sformatf("alt%0d_rdata", t), rdata,    er);
      tick();
      check($sformatf("alt%0d_ack_off", t), 32'(ack), 32'h0);
    end

    // ch0 alone, req held across ack: regranted in the cycle after ack
    set_ch(0, 1'b1, 2'd0, 17'h05000, 32'h0000005A);
    req = 2'b01;
    wait_ack(lat);
    check("b2b_lat1", 32'(lat), 32'd2);
    check("b2b_ack1", 32'(ack), 32'h1);
    set_ch(0, 1'b1, 2'd0, 17'h05001, 32'h0000006B);
    tick();
    check("b2b_gap_ack",  32'(ack),  32'h0);
    check("b2b_gap_busy", 32'(busy), 32'h0);
    tick();
    check("b2b_busy2", 32'(busy), 32'h1);
    check("b2b_gnt2",  32'(gnt),  32'h0);
    tick();
    check("b2b_ack2", 32'(ack), 32'h1);
    req = '0;
    tick();
    check("b2b_m0", 32'(mem[17'h05000]), 32'h5A);
    check("b2b_m1", 32'(mem[17'h05001]), 32'h6B);

    // req dropped and inputs changed after grant: transfer completes as latched
    set_ch(1, 1'b0, 2'd2, 17'h01000, 32'h0);
    req = 2'b10;
    tick();
    check("drop_gnt", 32'(gnt), 32'h1);
    req = '0;
    set_ch(1, 1'b0, 2'd0, 17'h02000, 32'h0);
    wait_ack(lat);
    check("drop_lat",   32'(lat + 1), 32'd5);
    check("drop_ack",   32'(ack),     32'h2);
    check("drop_rdata", rdata,        32'h11223344);
    tick();

    // DW=16 instance: word request rejected at grant+1, half accepted
    u_we = 2'b01; u_sz = 4'b0010; u_addr = '0; u_wdata = 32'h0000BEEF;
    u_req = 2'b01;
    tick();
    check("u16_err_ack",   32'(u_ack),   32'h1);
    check("u16_err_err",   32'(u_err),   32'h1);
    check("u16_err_rdata", 32'(u_rdata), 32'h0);
    check("u16_err_busy",  32'(u_busy),  32'h1);
    check("u16_err_gnt",   32'(u_gnt),   32'h0);
    u_req = '0;
    tick();
    check("u16_err_ack_off", 32'(u_ack), 32'h0);
    check("u16_err_hold",    32'(u_err), 32'h1);
    u_we = 2'b00; u_sz = 4'b0001; u_wdata = '0;
    u_req = 2'b01;
    tick(); tick();
    check("u16_half_early", 32'(u_ack), 32'h0);
    tick();
    check("u16_half_ack",   32'(u_ack),    32'h1);
    check("u16_half_err",   32'(u_err),    32'h0);
    check("u16_half_rdata", 32'(u_rdata),  32'h0);
    check("u16_half_mem_a", 32'(u_mem_a),  32'h1);
    check("u16_half_wd",    32'(u_mem_wd), 32'h0);
    u_req = '0;
    tick();
    check("u16_no_write", 32'(u_we_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
